// File: rtl/perf_counter_file.sv
// rtl/perf_counter_file.sv - cycle/instret/event performance counters with CSR access, inhibit and overflow irq
module perf_counter_file #(
   parameter int NUM_EVENTS = 4,
   parameter int CNT_WIDTH  = 64,
   parameter int XLEN       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  retire_i,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic                  csr_rd_en,
   input  logic                  csr_wr_en,
   input  logic [11:0]           csr_addr,
   input  logic [XLEN-1:0]       csr_wdata,
   output logic [XLEN-1:0]       csr_rdata,
   output logic                  csr_rvalid,
   output logic                  csr_err,
   output logic [NUM_EVENTS+2:0] ovf_o,
   output logic                  ovf_irq
);

   localparam int NC = NUM_EVENTS + 3;
   localparam logic [NC-1:0] W_MASK = ~(NC'(2));

   logic [CNT_WIDTH-1:0] r_cnt [NC];
   logic [NC-1:0]        r_inh;
   logic [NC-1:0]        r_ovf;
   logic [NC-1:0]        r_ove;
   logic [XLEN-1:0]      r_rdata;
   logic                 r_rvalid;
   logic                 r_err;

   logic [6:0]           w_n;
   logic                 w_hi;
   logic                 w_cnt_hit;
   logic                 w_inh_hit;
   logic                 w_ovs_hit;
   logic                 w_ove_hit;
   logic                 w_legal;
   logic                 w_wr;
   logic [NC-1:0]        w_src;
   logic [NC-1:0]        w_inc;
   logic [NC-1:0]        w_wr_sel;
   logic [NC-1:0]        w_ovf_set;
   logic [NC-1:0]        w_ovf_clr;
   logic [63:0]          w_cnt64 [NC];
   logic [XLEN-1:0]      w_rd_val;

   assign w_n       = csr_addr[6:0];
   assign w_hi      = csr_addr[7];
   assign w_cnt_hit = (csr_addr[11:8] == 4'hB) && (w_n != 7'd1) && (w_n < 7'(NC));
   assign w_inh_hit = (csr_addr == 12'h320);
   assign w_ovs_hit = (csr_addr == 12'h7C0);
   assign w_ove_hit = (csr_addr == 12'h7C1);
   assign w_legal   = w_cnt_hit | w_inh_hit | w_ovs_hit | w_ove_hit;
   assign w_wr      = csr_wr_en & w_legal;

   assign w_src     = {event_i, retire_i, 1'b0, 1'b1};
   assign w_inc     = w_src & ~r_inh;
   assign w_ovf_clr = (w_wr && w_ovs_hit) ? csr_wdata[NC-1:0] : '0;

   always_comb begin
      for (int k = 0; k < NC; k++) begin
         w_cnt64[k] = 64'(r_cnt[k]);
      end
   end

   always_comb begin
      w_wr_sel  = '0;
      w_ovf_set = '0;
      w_rd_val  = '0;
      for (int k = 0; k < NC; k++) begin
         if (w_cnt_hit && (w_n == 7'(k))) begin
            w_wr_sel[k] = csr_wr_en;
            w_rd_val    = w_hi ? w_cnt64[k][63:32] : w_cnt64[k][31:0];
         end
      end
      // A written counter skips its increment, so it cannot wrap that cycle.
      for (int k = 0; k < NC; k++) begin
         w_ovf_set[k] = w_inc[k] & ~w_wr_sel[k] & (&r_cnt[k]);
      end
      if (w_inh_hit) begin
         w_rd_val = 32'(r_inh);
      end else if (w_ovs_hit) begin
         w_rd_val = 32'(r_ovf);
      end else if (w_ove_hit) begin
         w_rd_val = 32'(r_ove);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NC; k++) begin
            r_cnt[k] <= '0;
         end
         r_inh    <= '0;
         r_ovf    <= '0;
         r_ove    <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         for (int k = 0; k < NC; k++) begin
            if (w_wr_sel[k]) begin
               if (w_hi) begin
                  r_cnt[k] <= CNT_WIDTH'({csr_wdata, w_cnt64[k][31:0]});
               end else begin
                  r_cnt[k] <= CNT_WIDTH'({w_cnt64[k][63:32], csr_wdata});
               end
            end else if (w_inc[k]) begin
               r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
            end
         end
         if (w_wr && w_inh_hit) begin
            r_inh <= csr_wdata[NC-1:0] & W_MASK;
         end
         if (w_wr && w_ove_hit) begin
            r_ove <= csr_wdata[NC-1:0] & W_MASK;
         end
         r_ovf    <= (w_ovf_set | (r_ovf & ~w_ovf_clr)) & W_MASK;
         r_rvalid <= csr_rd_en & w_legal;
         r_err    <= (csr_rd_en | csr_wr_en) & ~w_legal;
         if (csr_rd_en && w_legal) begin
            r_rdata <= w_rd_val;
         end
      end
   end

   assign csr_rdata  = r_rdata;
   assign csr_rvalid = r_rvalid;
   assign csr_err    = r_err;
   assign ovf_o      = r_ovf;
   assign ovf_irq    = |(r_ovf & r_ove);

endmodule

// File: tb/tb_perf_counter_file.sv
// tb/tb_perf_counter_file.sv - directed vector bench for perf_counter_file (64- and 40-bit instances)
module tb_perf_counter_file;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        retire_i = 1'b0;
   logic [3:0]  event_i = 4'h0;
   logic        csr_rd_en = 1'b0;
   logic        csr_wr_en = 1'b0;
   logic [11:0] csr_addr = 12'h0;
   logic [31:0] csr_wdata = 32'h0;

   logic [31:0] rdata, rdata40;
   logic        rvalid, rvalid40;
   logic        err, err40;
   logic [6:0]  ovf, ovf40;
   logic        irq, irq40;

   int n_chk  = 0;
   int n_pass = 0;

   perf_counter_file #(.NUM_EVENTS(4), .CNT_WIDTH(64), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .retire_i(retire_i), .event_i(event_i),
      .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(rdata), .csr_rvalid(rvalid), .csr_err(err), .ovf_o(ovf), .ovf_irq(irq)
   );

   perf_counter_file #(.NUM_EVENTS(4), .CNT_WIDTH(40), .XLEN(32)) dut40 (
      .clk(clk), .rst(rst), .retire_i(retire_i), .event_i(event_i),
      .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(rdata40), .csr_rvalid(rvalid40), .csr_err(err40), .ovf_o(ovf40), .ovf_irq(irq40)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        rvalid;
      logic        err;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr(input logic rd, input logic wr, input logic [11:0] a, input logic [31:0] d);
      csr_rd_en = rd;
      csr_wr_en = wr;
      csr_addr  = a;
      csr_wdata = d;
      tick();
      csr_rd_en = 1'b0;
      csr_wr_en = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 12'h320, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 12'h320, 32'h0,         32'h0000_007D, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 12'hB05, 32'h1234_5678, 32'h0000_007D, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 12'hB85, 32'hCAFE_F00D, 32'h0000_007D, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 12'hB05, 32'h0,         32'h1234_5678, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 12'hB85, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 12'hB05, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 12'hB85, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 12'hB05, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 12'hB05, 32'hAAAA_5555, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 12'hB05, 32'h0,         32'hAAAA_5555, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 12'hB01, 32'h0,         32'hAAAA_5555, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 12'hB01, 32'h0,         32'hAAAA_5555, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 12'hB07, 32'h0,         32'hAAAA_5555, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 12'hB87, 32'hFFFF_FFFF, 32'hAAAA_5555, 1'b0, 1'b1};
      tbl[15] = '{1'b1, 1'b1, 12'h123, 32'hFFFF_FFFF, 32'hAAAA_5555, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 12'h123, 32'h0,         32'hAAAA_5555, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 12'hB81, 32'h0,         32'hAAAA_5555, 1'b0, 1'b1};
      tbl[18] = '{1'b1, 1'b0, 12'hB06, 32'h0,         32'h0000_0000, 1'b1, 1'b0};
      tbl[19] = '{1'b1, 1'b0, 12'h7C1, 32'h0,         32'h0000_0008, 1'b1, 1'b0};
      tbl[20] = '{1'b1, 1'b0, 12'h7C0, 32'h0,         32'h0000_0000, 1'b1, 1'b0};
      tbl[21] = '{1'b1, 1'b0, 12'hB04, 32'h0,         32'h0000_0000, 1'b1, 1'b0};

      // reset state, then 10 cycles with 6 retires
      tick(); tick(); tick();
      chk("rst rdata", rdata, 0);
      chk("rst rvalid", rvalid, 0);
      chk("rst err", err, 0);
      chk("rst ovf", ovf, 0);
      chk("rst irq", irq, 0);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         retire_i = (i < 6);
         tick();
      end
      retire_i = 1'b0;
      csr(1'b1, 1'b0, 12'hB00, 32'h0);
      chk("cycle rdata", rdata, 32'd10);
      chk("cycle rvalid", rvalid, 1);
      chk("cycle err", err, 0);
      chk("cycle40 rdata", rdata40, 32'd10);
      csr(1'b1, 1'b0, 12'hB02, 32'h0);
      chk("instret rdata", rdata, 32'd6);
      chk("instret rvalid", rvalid, 1);
      tick();
      chk("idle rvalid", rvalid, 0);
      chk("idle rdata hold", rdata, 32'd6);

      // low-to-high carry on counter 3, write coincident with event
      csr(1'b0, 1'b1, 12'hB83, 32'h1);
      event_i = 4'b0001;
      csr(1'b0, 1'b1, 12'hB03, 32'hFFFF_FFFE);
      csr(1'b1, 1'b0, 12'hB03, 32'h0);
      chk("c3 lo step1", rdata, 32'hFFFF_FFFE);
      csr(1'b1, 1'b0, 12'hB03, 32'h0);
      chk("c3 lo step2", rdata, 32'hFFFF_FFFF);
      event_i = 4'b0000;
      csr(1'b1, 1'b0, 12'hB83, 32'h0);
      chk("c3 hi carry", rdata, 32'd2);
      csr(1'b1, 1'b0, 12'hB03, 32'h0);
      chk("c3 lo carry", rdata, 32'd0);
      chk("c3 no ovf", ovf, 0);

      // overflow on both widths, masked irq, W1C vs simultaneous set
      csr(1'b0, 1'b1, 12'h7C1, 32'h8);
      csr(1'b0, 1'b1, 12'hB83, 32'hFFFF_FFFF);
      csr(1'b1, 1'b0, 12'hB83, 32'h0);
      chk("hi64 rd", rdata, 32'hFFFF_FFFF);
      chk("hi40 truncated", rdata40, 32'h0000_00FF);
      csr(1'b0, 1'b1, 12'hB03, 32'hFFFF_FFFF);
      event_i = 4'b0001;
      tick();
      event_i = 4'b0000;
      chk("ovf40 flag", ovf40, 7'h08);
      chk("irq40", irq40, 1);
      chk("ovf64 flag", ovf, 7'h08);
      chk("irq64", irq, 1);
      csr(1'b1, 1'b0, 12'hB03, 32'h0);
      chk("wrap40 lo", rdata40, 0);
      csr(1'b1, 1'b0, 12'hB83, 32'h0);
      chk("wrap40 hi", rdata40, 0);
      chk("wrap64 hi", rdata, 0);
      csr(1'b0, 1'b1, 12'h7C1, 32'h0);
      chk("irq masked", irq, 0);
      chk("ovf kept masked", ovf, 7'h08);
      csr(1'b0, 1'b1, 12'h7C1, 32'h8);
      chk("irq unmasked", irq, 1);
      csr(1'b0, 1'b1, 12'hB83, 32'hFFFF_FFFF);
      csr(1'b0, 1'b1, 12'hB03, 32'hFFFF_FFFF);
      event_i = 4'b0001;
      csr(1'b0, 1'b1, 12'h7C0, 32'h8);
      event_i = 4'b0000;
      chk("w1c set wins", ovf40, 7'h08);
      chk("w1c set wins 64", ovf, 7'h08);
      csr(1'b0, 1'b1, 12'h7C0, 32'h8);
      chk("w1c clears", ovf40, 0);
      chk("w1c irq", irq40, 0);
      csr(1'b1, 1'b0, 12'h7C0, 32'h0);
      chk("ovf status rd", rdata, 0);

      // table-driven CSR vectors with all counters inhibited
      for (int i = 0; i < NV; i++) begin
         csr(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
         chk($sformatf("vec%0d rdata", i), rdata, tbl[i].rdata);
         chk($sformatf("vec%0d rvalid", i), rvalid, tbl[i].rvalid);
         chk($sformatf("vec%0d err", i), err, tbl[i].err);
      end

      // inhibit cycle and instret while event counter 4 keeps counting
      csr(1'b0, 1'b1, 12'h320, 32'h5);
      csr(1'b0, 1'b1, 12'hB00, 32'd100);
      csr(1'b1, 1'b0, 12'hB00, 32'h0);
      chk("inh cycle before", rdata, 32'd100);
      csr(1'b1, 1'b0, 12'hB02, 32'h0);
      chk("inh instret before", rdata, 32'd6);
      retire_i = 1'b1;
      event_i  = 4'b0010;
      for (int i = 0; i < 20; i++) tick();
      retire_i = 1'b0;
      event_i  = 4'b0000;
      csr(1'b1, 1'b0, 12'hB00, 32'h0);
      chk("inh cycle held", rdata, 32'd100);
      csr(1'b1, 1'b0, 12'hB02, 32'h0);
      chk("inh instret held", rdata, 32'd6);
      csr(1'b1, 1'b0, 12'hB04, 32'h0);
      chk("inh ev4 counts", rdata, 32'd20);
      csr(1'b0, 1'b1, 12'h320, 32'h0);
      csr(1'b1, 1'b0, 12'hB00, 32'h0);
      chk("resume cycle0", rdata, 32'd100);
      csr(1'b1, 1'b0, 12'hB00, 32'h0);
      chk("resume cycle1", rdata, 32'd101);
      retire_i = 1'b1;
      csr(1'b1, 1'b0, 12'hB02, 32'h0);
      retire_i = 1'b0;
      chk("resume instret0", rdata, 32'd6);
      csr(1'b1, 1'b0, 12'hB02, 32'h0);
      chk("resume instret1", rdata, 32'd7);

      // asynchronous reset coincident with a pending read
      csr_rd_en = 1'b1;
      csr_addr  = 12'hB00;
      #2;
      rst = 1'b0;
      #1;
      chk("arst rdata", rdata, 0);
      chk("arst rvalid", rvalid, 0);
      chk("arst rdata40", rdata40, 0);
      tick();
      chk("arst held rvalid", rvalid, 0);
      rst = 1'b1;
      csr_rd_en = 1'b0;
      tick();
      chk("post rst rvalid", rvalid, 0);
      chk("post rst rdata", rdata, 0);
      csr(1'b1, 1'b0, 12'hB00, 32'h0);
      chk("post rst cycle", rdata, 32'd1);
      csr(1'b1, 1'b0, 12'hB04, 32'h0);
      chk("post rst ev4", rdata, 0);
      csr(1'b1, 1'b0, 12'h320, 32'h0);
      chk("post rst inhibit", rdata, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/perf_counter_file.md
Name: perf_counter_file

Overview:
- Parametrised performance-counter CSR block in the CPU core: cycle, instret and NUM_EVENTS programmable-event counters, each CNT_WIDTH bits wide.
- Adds to the basic counters: CSR writes, per-counter inhibit (mcountinhibit), sticky overflow flags with an interrupt, and registered reads with illegal-address detection.
- Feeds the CSR read mux in EX; events come from the pipeline and the memory stall logic.

Parameters:
- NUM_EVENTS, 4, number of hpmcounter event counters, range 1..29
- CNT_WIDTH, 64, counter width in bits, range 33..64
- XLEN, 32, CSR data width, fixed at 32

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- retire_i  in  1  one valid instruction retired this cycle
- event_i  in  NUM_EVENTS  event pulses; bit i increments hpmcounter(3+i)
- csr_rd_en  in  1  CSR read request
- csr_wr_en  in  1  CSR write request
- csr_addr  in  12  CSR address
- csr_wdata  in  32  CSR write data
- csr_rdata  out  32  read data, registered
- csr_rvalid  out  1  read data valid, one-cycle pulse
- csr_err  out  1  illegal access, one-cycle pulse
- ovf_o  out  NUM_EVENTS+3  sticky overflow flags, indexed by counter number (bit 1 always 0)
- ovf_irq  out  1  OR of (ovf_o AND ovf_en)

Behaviour:
- Counter numbering:
  - 0 = cycle, increments every cycle.
  - 1 = time, unimplemented.
  - 2 = instret, increments when retire_i.
  - 3+i = event counter, increments when event_i[i].
  - Increments are +1 at most per cycle.
- Address map:
  - Low half of counter n: 0xB00+n.
  - High half of counter n: 0xB80+n.
  - mcountinhibit: 0x320; bit n inhibits counter n; bit 1 reads 0; writable bits are 0, 2, 3..2+NUM_EVENTS.
  - ovf status: 0x7C0; read = ovf_o; write-1-to-clear.
  - ovf enable: 0x7C1; read/write.
  - Any other address, or counter n=1, or n>2+NUM_EVENTS, is illegal.
- Reset (rst low, asynchronous):
  - All counters, inhibit, ovf flags, ovf enable, csr_rdata, csr_rvalid and csr_err go to 0.
  - Reset mid-operation discards any pending read; outputs stay 0 until rst is high and the next clk edge.
- Width:
  - High half returns bits [CNT_WIDTH-1:32], zero-extended; unused upper bits read 0 and ignore writes.
  - Counters wrap from 2^CNT_WIDTH-1 to 0.
- Read latency: 1 cycle.
  - A csr_rd_en at edge k yields csr_rdata/csr_rvalid after edge k.
  - The value returned is the register state before edge k, so it excludes that cycle's increment or write.
  - When not reading, csr_rdata holds its last value and csr_rvalid=0.
- Write:
  - Takes effect at the edge.
  - A write to one half replaces only that half; the other half is unchanged.
  - The written counter does not increment in that cycle.
  - A write to low does not carry into high.
- Simultaneous read and write, same address: the read returns the old value.
- Illegal access:
  - csr_rd_en or csr_wr_en to an illegal address pulses csr_err one cycle later; state is unchanged.
  - An illegal read gives csr_rvalid=0 and csr_rdata holds its last value.
  - csr_rd_en and csr_wr_en together on an illegal address produce a single err pulse.
- Inhibit: an inhibited counter holds its value but remains readable and writable.
- Overflow:
  - The flag for counter n sets when an increment wraps counter n to 0. Writes never set flags.
  - A W1C in the same cycle as a new overflow on that bit: set wins.
  - ovf_irq is combinational from the flops, with no added latency.

Test Plan:
- Reset then release; run 10 cycles with retire_i=1 for 6 of them; read 0xB00 and 0xB02 -> rdata=10 (cycle at the request edge) and 6, rvalid one cycle after each request, err=0.
- Write 0xB83=0x0000_0001 and 0xB03=0xFFFF_FFFE, pulse event_i[0] for 3 cycles -> counter3 = 0x1_FFFF_FFFE, 0x1_FFFF_FFFF, then 0x2_0000_0000; high read returns 2, low read returns 0.
- CNT_WIDTH=40: write counter3 = 0xFF_FFFF_FFFF, set ovf_en bit3, one event pulse -> counter3=0, ovf_o[3]=1, ovf_irq=1. W1C 0x7C0 bit3 with a simultaneous event-driven wrap -> flag stays 1; W1C alone -> flag 0, irq 0.
- Write mcountinhibit=0x5 -> cycle and instret hold for 20 cycles while event counters still count; write 0 -> counting resumes from the held values.
- Read and write to 0xB01, 0xB00+NUM_EVENTS+3 and 0x123 -> csr_err pulse, rvalid=0, no state change.
- Drive rst low mid-count, coincident with a csr_rd_en -> rdata, rvalid and all counters are 0 immediately; no rvalid after release.
